// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache lookup controller: one outstanding lookup, line fill on miss,
// bulk invalidate and saturating hit/miss statistics.
module dm_cache_ctrl #(
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [TAG_W+IDX_W-1:0]  req_addr,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic                    rsp_miss,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    fill_req,
    output logic [TAG_W+IDX_W-1:0]  fill_addr,
    input  logic                    fill_valid,
    input  logic [DATA_W-1:0]       fill_data,
    input  logic                    inv_all,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count
);
    localparam int unsigned Depth = 1 << IDX_W;
    localparam int unsigned AddrW = TAG_W + IDX_W;

    typedef enum logic [1:0] {StIdle, StLookup, StMissWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [AddrW-1:0]    addr_q;
    logic [Depth-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_arr [Depth];
    logic [DATA_W-1:0]   data_arr [Depth];
    logic                rsp_hit_q, rsp_miss_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic                lookup_hit;
    logic                accept;
    logic                fill_take;

    assign idx        = addr_q[IDX_W-1:0];
    assign tag        = addr_q[AddrW-1:IDX_W];
    assign lookup_hit = valid_q[idx] && (tag_arr[idx] == tag);
    assign accept     = req_valid && req_ready;
    assign fill_take  = (state_q == StMissWait) && fill_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (accept) state_d = StLookup;
            StLookup:   state_d = lookup_hit ? StResp : StMissWait;
            StMissWait: if (fill_valid) state_d = StResp;
            StResp:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle) && !inv_all;
        rsp_valid = (state_q == StResp);
        fill_req  = (state_q == StMissWait);
    end

    // Flags are held after RESP, so gate them to keep the strobe contract clean.
    assign rsp_hit    = rsp_valid && rsp_hit_q;
    assign rsp_miss   = rsp_valid && rsp_miss_q;
    assign rsp_data   = rsp_data_q;
    assign fill_addr  = fill_req ? addr_q : '0;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            valid_q    <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_miss_q <= 1'b0;
            rsp_data_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
            end
            if ((state_q == StIdle) && inv_all) begin
                valid_q <= '0;
            end else if (fill_take) begin
                valid_q[idx] <= 1'b1;
            end
            if (state_q == StLookup) begin
                if (lookup_hit) begin
                    rsp_hit_q  <= 1'b1;
                    rsp_miss_q <= 1'b0;
                    rsp_data_q <= data_arr[idx];
                    if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                end
            end
            if (fill_take) begin
                rsp_hit_q  <= 1'b0;
                rsp_miss_q <= 1'b1;
                rsp_data_q <= fill_data;
            end
        end
    end

    // Tag/data storage is not reset; only valid bits qualify it.
    always_ff @(posedge clk) begin
        if (!reset && fill_take) begin
            tag_arr[idx]  <= tag;
            data_arr[idx] <= fill_data;
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: transaction-level cache model with per-cycle compare,
// a second instance with 2-bit counters for saturation.
module tb_dm_cache_ctrl;
    logic        clk = 1'b0;
    logic        reset, req_valid, inv_all, fill_valid;
    logic [11:0] req_addr;
    logic [7:0]  fill_data;

    logic        req_ready, rsp_valid, rsp_hit, rsp_miss, fill_req;
    logic [7:0]  rsp_data;
    logic [11:0] fill_addr;
    logic [15:0] hit_count, miss_count;

    logic        req_ready2, rsp_valid2, rsp_hit2, rsp_miss2, fill_req2;
    logic [7:0]  rsp_data2;
    logic [11:0] fill_addr2;
    logic [1:0]  hit_count2, miss_count2;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_miss(rsp_miss),
        .rsp_data(rsp_data), .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_valid(fill_valid), .fill_data(fill_data), .inv_all(inv_all),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    dm_cache_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
        .req_addr(req_addr), .rsp_valid(rsp_valid2), .rsp_hit(rsp_hit2), .rsp_miss(rsp_miss2),
        .rsp_data(rsp_data2), .fill_req(fill_req2), .fill_addr(fill_addr2),
        .fill_valid(fill_valid), .fill_data(fill_data), .inv_all(inv_all),
        .hit_count(hit_count2), .miss_count(miss_count2)
    );

    // Reference cache contents and statistics
    bit          m_valid [16];
    logic [7:0]  m_tag   [16];
    logic [7:0]  m_data  [16];
    int          m_hits, m_misses;

    // Expected outputs for the current cycle
    bit          exp_ready, exp_rsp, exp_hit, exp_fill;
    logic [7:0]  exp_data;
    logic [11:0] exp_faddr;

    bit          checking, noisy;
    int          checks, errors;
    logic        last_hit, last_miss;
    logic [7:0]  last_data;
    logic [11:0] last_faddr;

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (rsp_valid) begin
                last_hit  = rsp_hit;
                last_miss = rsp_miss;
                last_data = rsp_data;
            end
            if (fill_req) last_faddr = fill_addr;
            chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp});
            chk("fill_req", {31'b0, fill_req}, {31'b0, exp_fill});
            chk("req_ready2", {31'b0, req_ready2}, {31'b0, exp_ready});
            chk("rsp_valid2", {31'b0, rsp_valid2}, {31'b0, exp_rsp});
            chk("fill_req2", {31'b0, fill_req2}, {31'b0, exp_fill});
            if (exp_rsp) begin
                chk("rsp_hit", {31'b0, rsp_hit}, {31'b0, exp_hit});
                chk("rsp_miss", {31'b0, rsp_miss}, {31'b0, !exp_hit});
                chk("rsp_data", {24'b0, rsp_data}, {24'b0, exp_data});
                chk("rsp_hit2", {31'b0, rsp_hit2}, {31'b0, exp_hit});
                chk("rsp_miss2", {31'b0, rsp_miss2}, {31'b0, !exp_hit});
                chk("rsp_data2", {24'b0, rsp_data2}, {24'b0, exp_data});
            end
            if (exp_fill) begin
                chk("fill_addr", {20'b0, fill_addr}, {20'b0, exp_faddr});
                chk("fill_addr2", {20'b0, fill_addr2}, {20'b0, exp_faddr});
            end
            chk("hit_count", {16'b0, hit_count}, sat(m_hits, 65535));
            chk("miss_count", {16'b0, miss_count}, sat(m_misses, 65535));
            chk("hit_count2", {30'b0, hit_count2}, sat(m_hits, 3));
            chk("miss_count2", {30'b0, miss_count2}, sat(m_misses, 3));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_valid  = 1'b0;
        inv_all    = 1'b0;
        fill_valid = 1'b0;
    endtask

    task automatic noise();
        if (noisy) begin
            inv_all    = 1'($urandom);
            req_valid  = 1'($urandom);
            req_addr   = 12'($urandom);
            fill_valid = 1'($urandom);
            fill_data  = 8'($urandom);
        end
    endtask

    // One IDLE cycle; a request raised here is only legal alongside inv_all.
    task automatic idle_cycle(bit inv, bit rv, logic [11:0] a, bit fv, logic [7:0] fd);
        inv_all    = inv;
        req_valid  = rv && inv;
        req_addr   = a;
        fill_valid = fv;
        fill_data  = fd;
        exp_ready  = !inv;
        exp_rsp    = 1'b0;
        exp_fill   = 1'b0;
        step();
        if (inv) foreach (m_valid[i]) m_valid[i] = 1'b0;
        quiet();
        exp_ready = 1'b1;
    endtask

    task automatic do_req(logic [11:0] a, int lat, logic [7:0] fd);
        logic [3:0] idx;
        bit         hit;
        idx = a[3:0];
        hit = m_valid[idx] && (m_tag[idx] == a[11:4]);
        quiet();
        req_valid = 1'b1;
        req_addr  = a;
        exp_ready = 1'b1;
        step();
        exp_ready = 1'b0;
        quiet();
        noise();
        step();
        quiet();
        if (hit) begin
            m_hits++;
            exp_rsp  = 1'b1;
            exp_hit  = 1'b1;
            exp_data = m_data[idx];
        end else begin
            m_misses++;
            exp_fill  = 1'b1;
            exp_faddr = a;
            for (int i = 0; i < lat; i++) begin
                noise();
                fill_valid = 1'b0;
                step();
            end
            quiet();
            fill_valid = 1'b1;
            fill_data  = fd;
            step();
            quiet();
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[11:4];
            m_data[idx]  = fd;
            exp_fill = 1'b0;
            exp_rsp  = 1'b1;
            exp_hit  = 1'b0;
            exp_data = fd;
        end
        noise();
        step();
        quiet();
        exp_rsp   = 1'b0;
        exp_ready = 1'b1;
    endtask

    // Miss, then a one-cycle reset while the fill is outstanding.
    task automatic reset_in_miss(logic [11:0] a);
        quiet();
        req_valid = 1'b1;
        req_addr  = a;
        exp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        exp_ready = 1'b0;
        step();
        m_misses++;
        exp_fill  = 1'b1;
        exp_faddr = a;
        reset = 1'b1;
        step();
        reset = 1'b0;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_hits    = 0;
        m_misses  = 0;
        exp_fill  = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; checking = 1'b0; noisy = 1'b0;
        m_hits = 0; m_misses = 0;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        exp_ready = 1'b1; exp_rsp = 1'b0; exp_hit = 1'b0; exp_fill = 1'b0;
        exp_data = '0; exp_faddr = '0;
        req_addr = '0; fill_data = '0;
        quiet();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checking = 1'b1;

        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_hit", {31'b0, rsp_hit}, 0);
        chk("rst_rsp_miss", {31'b0, rsp_miss}, 0);
        chk("rst_fill_req", {31'b0, fill_req}, 0);
        chk("rst_rsp_data", {24'b0, rsp_data}, 0);
        chk("rst_fill_addr", {20'b0, fill_addr}, 0);
        chk("rst_counts", {hit_count, miss_count}, 0);

        do_req(12'h035, 2, 8'hA5);
        chk("tp1_miss", {31'b0, last_miss}, 1);
        chk("tp1_data", {24'b0, last_data}, 32'hA5);
        chk("tp1_fill_addr", {20'b0, last_faddr}, 32'h035);
        chk("tp1_miss_count", {16'b0, miss_count}, 1);

        do_req(12'h035, 0, 8'h00);
        chk("tp2_hit", {31'b0, last_hit}, 1);
        chk("tp2_data", {24'b0, last_data}, 32'hA5);
        chk("tp2_hit_count", {16'b0, hit_count}, 1);

        do_req(12'h045, 1, 8'h3C);
        do_req(12'h035, 0, 8'hA5);
        do_req(12'h045, 3, 8'h3C);
        chk("tp3_evict_miss", {31'b0, last_miss}, 1);
        chk("tp3_miss_count", {16'b0, miss_count}, 4);
        do_req(12'h035, 1, 8'hA5);
        do_req(12'h035, 0, 8'h00);
        chk("tp3_rehit", {31'b0, last_hit}, 1);

        idle_cycle(1'b1, 1'b1, 12'h035, 1'b0, 8'h00);
        do_req(12'h035, 0, 8'h77);
        chk("tp4_inv_miss", {31'b0, last_miss}, 1);
        chk("tp4_inv_data", {24'b0, last_data}, 32'h77);

        reset_in_miss(12'h045);
        chk("tp5_fill_req", {31'b0, fill_req}, 0);
        chk("tp5_counts", {hit_count, miss_count}, 0);
        idle_cycle(1'b0, 1'b0, 12'h000, 1'b1, 8'hFF);
        do_req(12'h035, 1, 8'h11);
        chk("tp5_miss", {31'b0, last_miss}, 1);
        chk("tp5_data", {24'b0, last_data}, 32'h11);

        for (int i = 1; i <= 4; i++) do_req(12'h0A0 + 12'(i), 0, 8'(i));
        chk("tp6_miss_sat2", {30'b0, miss_count2}, 3);
        chk("tp6_hit_sat2", {30'b0, hit_count2}, 0);
        chk("tp6_miss16", {16'b0, miss_count}, 5);

        noisy = 1'b1;
        for (int n = 0; n < 250; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                idle_cycle(1'b1, 1'($urandom), 12'($urandom), 1'($urandom), 8'($urandom));
            end else if (r == 1) begin
                idle_cycle(1'b0, 1'b0, 12'($urandom), 1'($urandom), 8'($urandom));
            end else begin
                do_req({6'b0, 2'($urandom), 4'($urandom)}, int'($urandom_range(0, 3)),
                       8'($urandom));
            end
        end
        step();
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Parametrised direct-mapped cache lookup controller; successor to the single-bit valid/tag hit-miss FSM. Holds a 2^IDX_W-entry tag/valid/data store and accepts one lookup at a time over a valid/ready handshake. On a miss it requests a line fill from the next level and writes the returned data into the store. Sits between a requester (core/load unit) and the memory-side fill interface. Also provides bulk invalidate and saturating hit/miss statistics.

Parameters:
TAG_W, 8, tag field width in bits
IDX_W, 4, index width in bits; cache depth = 2^IDX_W lines
DATA_W, 8, data word per line in bits
CNT_W, 16, width of hit/miss statistic counters

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous active-high reset
req_valid  in  1  lookup request present
req_ready  out  1  controller can accept request
req_addr  in  TAG_W+IDX_W  address; tag = [TAG_W+IDX_W-1:IDX_W], index = [IDX_W-1:0]
rsp_valid  out  1  response strobe, one cycle
rsp_hit  out  1  response was a hit (valid only with rsp_valid)
rsp_miss  out  1  response was a miss (valid only with rsp_valid)
rsp_data  out  DATA_W  line data (valid only with rsp_valid)
fill_req  out  1  miss outstanding, fill requested
fill_addr  out  TAG_W+IDX_W  address of the outstanding miss
fill_valid  in  1  fill data returned
fill_data  in  DATA_W  returned line data
inv_all  in  1  invalidate all lines
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high, sampled on posedge clk.
- Reset result: state IDLE, all valid bits 0, counters 0, rsp_valid/rsp_hit/rsp_miss/fill_req 0, rsp_data 0, fill_addr 0. Tag/data arrays are not cleared.
- FSM states: IDLE, LOOKUP, MISS_WAIT, RESP.
- IDLE: req_ready = !inv_all. Handshake req_valid && req_ready at edge k latches req_addr and enters LOOKUP.
- LOOKUP (cycle k+1): hit = valid[idx] && tag_arr[idx] == tag. On hit, go to RESP with hit flag and data_arr[idx] registered. On miss, go to MISS_WAIT.
- MISS_WAIT: fill_req = 1 and fill_addr = latched address, held until fill_valid is sampled. On fill_valid: tag_arr[idx] <= tag, data_arr[idx] <= fill_data, valid[idx] <= 1, go to RESP with miss flag and fill_data.
- RESP: rsp_valid = 1 for exactly one cycle, with rsp_hit XOR rsp_miss = 1. Return to IDLE.
- Latency: hit gives rsp_valid in cycle k+2. Miss gives rsp_valid in the cycle after fill_valid is sampled. No back-to-back acceptance: the next request can be taken no earlier than the cycle after RESP.
- Counters: hit_count +1 on LOOKUP hit; miss_count +1 on LOOKUP miss. Each saturates at 2^CNT_W-1 (no wrap).
- inv_all in IDLE: all valid bits cleared at that edge. Takes priority over a simultaneous req_valid (not accepted, req_ready=0). inv_all outside IDLE is ignored (not queued).
- fill_valid outside MISS_WAIT: ignored, no array write.
- Reset in any state (including MISS_WAIT): abort to IDLE next cycle. No array write; fill_req drops.
- Replacement: direct-mapped; fill overwrites the indexed line unconditionally (no writeback).

Test Plan:
(defaults TAG_W=8, IDX_W=4, DATA_W=8)
- Reset, then req 0x035 -> rsp miss in LOOKUP; fill_req=1, fill_addr=0x035; drive fill_valid with data 0xA5 -> next cycle rsp_valid=1, rsp_miss=1, rsp_data=0xA5, miss_count=1.
- Repeat req 0x035 accepted at edge k -> rsp_valid at k+2, rsp_hit=1, rsp_data=0xA5, fill_req stays 0, hit_count=1.
- Conflict: req 0x045 (idx 5, tag 0x04) -> miss, fill 0x3C; then req 0x035 -> miss (line evicted); req 0x045 after that refill -> miss again (evicted by 0x035).
- inv_all and req_valid both high in IDLE -> req_ready=0, request not taken. Next-cycle req 0x035 (previously cached) -> miss.
- Assert reset for one cycle during MISS_WAIT -> IDLE next cycle, fill_req=0, counters 0. Later fill_valid with 0xFF produces no response; req 0x035 -> miss.
- CNT_W=2: 5 distinct-index misses -> miss_count=3 (saturated), hit_count=0.
